// File: rtl/wb_axil_bridge.sv
// ============================================================================
// Module   : wb_axil_bridge
// Brief    : Wishbone classic slave to AXI-Lite master, one transaction in flight.
//            Optional hung-slave timeout enabled by defining WB_AXIL_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_axil_bridge #(
  parameter int          ADDR_W    = 15,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK = 32'hFFFF_8000,
  parameter int          TIMEOUT   = 255
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic [31:0]       wbs_adr,
  input  logic [31:0]       wbs_wdata,
  input  logic [3:0]        wbs_sel,
  input  logic              wbs_cyc,
  input  logic              wbs_stb,
  input  logic              wbs_we,
  output logic              wbs_ack,
  output logic [31:0]       wbs_rdata,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
`ifdef WB_AXIL_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RD_A  = 3'd3;
  localparam logic [2:0] S_RD_D  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_aw_done;
  logic              r_w_done;
  logic [31:0]       r_rdata;
  logic              w_req;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wait;
  logic              w_timeout;

  assign w_req   = wbs_cyc & wbs_stb & ((wbs_adr & BASE_MASK) == BASE_ADDR);
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;
  assign w_wait  = (r_state == S_WR) | (r_state == S_WRESP) |
                   (r_state == S_RD_A) | (r_state == S_RD_D);

`ifdef WB_AXIL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  assign w_timeout   = w_wait & (r_cnt == CNT_W'(TIMEOUT));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_cnt <= '0;
      else if (w_wait)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = wbs_we ? S_WR : S_RD_A;
      S_WR:    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_next = S_WRESP;
      S_WRESP: if (m_bvalid) w_next = S_ACK;
      S_RD_A:  if (m_arready) w_next = S_RD_D;
      S_RD_D:  if (m_rvalid) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // A hung slave is abandoned regardless of which wait state we are in.
    if (w_timeout)
      w_next = S_ACK;
  end

  always_comb begin
    m_awvalid = (r_state == S_WR) & ~r_aw_done;
    m_wvalid  = (r_state == S_WR) & ~r_w_done;
    m_bready  = (r_state == S_WRESP);
    m_arvalid = (r_state == S_RD_A);
    m_rready  = (r_state == S_RD_D);
    // A master that has already left the cycle must not see a stray ack.
    wbs_ack   = (r_state == S_ACK) & wbs_cyc;
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_addr    <= wbs_adr[ADDR_W-1:0];
        r_wdata   <= wbs_wdata;
        r_wstrb   <= wbs_sel;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs)
        r_aw_done <= 1'b1;
      if (w_w_hs)
        r_w_done <= 1'b1;
      if (r_state == S_RD_D && m_rvalid)
        r_rdata <= m_rdata;
      if (w_timeout)
        r_rdata <= 32'hDEAD_BEEF;
    end
  end

  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign wbs_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_axil_bridge.sv
// ============================================================================
// Module   : tb_wb_axil_bridge
// Brief    : Vector-table bench for wb_axil_bridge with a delay-programmable AXI-Lite slave.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_axil_bridge;

  logic        clk = 1'b0;
  logic        axi_reset_n;
  logic [31:0] wbs_adr, wbs_wdata, wbs_rdata;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc, wbs_stb, wbs_we, wbs_ack;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;
  logic [14:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  always #5 clk = ~clk;

  wb_axil_bridge dut (
    .axi_clk(clk), .axi_reset_n(axi_reset_n),
    .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] sl_rdata;
    int          aw_dly, w_dly, ar_dly, r_dly, b_dly;
    logic        exp_hit;
    logic [31:0] exp_addr;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    int          lat;
  } resp_t;

  resp_t sb_q[$];
  vec_t  vecs[8];
  vec_t  post_rst;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_rdata;

  // Slave model state
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int aw_cyc, w_cyc, ar_cyc;
  int aw_dly, w_dly, ar_dly, r_dly, b_dly;
  logic aw_done, w_done, ar_done, b_given, r_given, b_rdy_seen, r_rdy_seen;
  logic [31:0] exp_addr, exp_wdata, sl_rdata;
  logic [3:0]  exp_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic slv_clear();
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
    aw_done = 0; w_done = 0; ar_done = 0; b_given = 0; r_given = 0;
    b_rdy_seen = 0; r_rdy_seen = 0;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
  endtask

  // Called on every falling edge: retires handshakes from the preceding rising
  // edge, checks payloads of live requests and schedules the next responses.
  task automatic slave_step();
    if (m_awready) begin aw_done = 1; m_awready = 0; end
    if (m_wready)  begin w_done  = 1; m_wready  = 0; end
    if (m_arready) begin ar_done = 1; m_arready = 0; end
    if (m_bvalid && b_rdy_seen) m_bvalid = 0;
    if (m_rvalid && r_rdy_seen) m_rvalid = 0;
    if (m_awvalid) begin
      aw_cyc++;
      chk("awaddr", 32'(m_awaddr), exp_addr);
      if (aw_wait >= aw_dly) m_awready = 1; else aw_wait++;
    end
    if (m_wvalid) begin
      w_cyc++;
      chk("wdata", m_wdata, exp_wdata);
      chk("wstrb", 32'(m_wstrb), 32'(exp_wstrb));
      if (w_wait >= w_dly) m_wready = 1; else w_wait++;
    end
    if (m_arvalid) begin
      ar_cyc++;
      chk("araddr", 32'(m_araddr), exp_addr);
      if (ar_wait >= ar_dly) m_arready = 1; else ar_wait++;
    end
    if (aw_done && w_done && !b_given) begin
      if (b_wait >= b_dly) begin m_bvalid = 1; b_given = 1; end else b_wait++;
    end
    if (ar_done && !r_given) begin
      if (r_wait >= r_dly) begin m_rvalid = 1; m_rdata = sl_rdata; r_given = 1; end
      else r_wait++;
    end
    b_rdy_seen = m_bready;
    r_rdy_seen = m_rready;
  endtask

  task automatic do_txn(input vec_t v);
    resp_t e;
    logic  got_ack;
    int    bound;
    slv_clear();
    aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly; r_dly = v.r_dly; b_dly = v.b_dly;
    exp_addr = v.exp_addr; exp_wdata = v.wdata; exp_wstrb = v.sel; sl_rdata = v.sl_rdata;
    @(posedge clk); #1;
    wbs_adr = v.adr; wbs_wdata = v.wdata; wbs_sel = v.sel; wbs_we = v.we;
    wbs_cyc = 1; wbs_stb = 1;
    if (v.exp_hit)
      sb_q.push_back('{we: v.we, rdata: (v.we ? last_rdata : v.sl_rdata), lat: v.exp_lat});
    got_ack = 0;
    bound = v.exp_hit ? 40 : 8;
    for (int k = 0; k < bound && !got_ack; k++) begin
      @(negedge clk);
      slave_step();
      if (!v.exp_hit) chk("miss_busy", 32'(busy), 32'd0);
      if (wbs_ack) begin
        got_ack = 1;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", 32'(k), 32'(e.lat));
          chk(e.we ? "rdata_hold" : "rdata", wbs_rdata, e.rdata);
          chk("busy_at_ack", 32'(busy), 32'd1);
          if (!e.we) last_rdata = e.rdata;
        end
        wbs_cyc = 0; wbs_stb = 0;
      end
    end
    wbs_cyc = 0; wbs_stb = 0;
    chk("ack_seen", 32'(got_ack), 32'(v.exp_hit));
    chk("aw_cycles", 32'(aw_cyc), (v.exp_hit && v.we)  ? 32'(v.aw_dly + 1) : 32'd0);
    chk("w_cycles",  32'(w_cyc),  (v.exp_hit && v.we)  ? 32'(v.w_dly + 1)  : 32'd0);
    chk("ar_cycles", 32'(ar_cyc), (v.exp_hit && !v.we) ? 32'(v.ar_dly + 1) : 32'd0);
    @(negedge clk);
    slave_step();
    chk("ack_one_cycle", 32'(wbs_ack), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   acks;
    vecs[0] = '{1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 32'h0,         0, 0, 0, 0, 0, 1'b1, 32'h0000_0010, 3};
    vecs[1] = '{1'b1, 32'h3000_0020, 32'hA5A5_0001, 4'h3, 32'h0,         3, 0, 0, 0, 0, 1'b1, 32'h0000_0020, 6};
    vecs[2] = '{1'b0, 32'h3000_7FFC, 32'h0,         4'hF, 32'hCAFE_F00D, 0, 0, 0, 5, 0, 1'b1, 32'h0000_7FFC, 8};
    vecs[3] = '{1'b1, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 0, 0, 0, 0, 1'b0, 32'h0,         0};
    vecs[4] = '{1'b1, 32'h3000_0100, 32'hDEAD_CAFE, 4'h8, 32'h0,         0, 2, 0, 0, 1, 1'b1, 32'h0000_0100, 6};
    vecs[5] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'h0BAD_1DEA, 0, 0, 2, 0, 0, 1'b1, 32'h0000_0004, 5};
    vecs[6] = '{1'b0, 32'h3000_8000, 32'h0,         4'hF, 32'h0,         0, 0, 0, 0, 0, 1'b0, 32'h0,         0};
    vecs[7] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h8000_0001, 0, 0, 0, 0, 0, 1'b1, 32'h0000_0000, 3};
    post_rst = '{1'b0, 32'h3000_1234, 32'h0,        4'hF, 32'h1357_9BDF, 0, 0, 0, 0, 0, 1'b1, 32'h0000_1234, 3};

    axi_reset_n = 0;
    wbs_adr = 0; wbs_wdata = 0; wbs_sel = 0; wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    m_rdata = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0;
    exp_addr = 0; exp_wdata = 0; exp_wstrb = 0; sl_rdata = 0;
    slv_clear();
    last_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, wbs_ack, busy}), 32'd0);
    chk("reset_rdata", wbs_rdata, 32'h0);
    axi_reset_n = 1;

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i]);

    // Master abandons the cycle after acceptance: AXI side still completes, no ack.
    slv_clear();
    aw_dly = 0; w_dly = 0; b_dly = 0;
    exp_addr = 32'h0000_0040; exp_wdata = 32'h1122_3344; exp_wstrb = 4'hF;
    @(posedge clk); #1;
    wbs_adr = 32'h3000_0040; wbs_wdata = 32'h1122_3344; wbs_sel = 4'hF; wbs_we = 1;
    wbs_cyc = 1; wbs_stb = 1;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      slave_step();
      if (wbs_ack) acks++;
      if (k == 1) begin wbs_cyc = 0; wbs_stb = 0; end
    end
    chk("drop_ack_count", 32'(acks), 32'd0);
    chk("drop_b_done", 32'(b_given), 32'd1);
    chk("drop_aw_cycles", 32'(aw_cyc), 32'd1);
    chk("drop_busy", 32'(busy), 32'd0);

    // Reset while parked in the write-response wait.
    slv_clear();
    aw_dly = 0; w_dly = 0; b_dly = 10;
    exp_addr = 32'h0000_0080; exp_wdata = 32'h5555_AAAA; exp_wstrb = 4'hF;
    @(posedge clk); #1;
    wbs_adr = 32'h3000_0080; wbs_wdata = 32'h5555_AAAA; wbs_sel = 4'hF; wbs_we = 1;
    wbs_cyc = 1; wbs_stb = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      slave_step();
      if (m_bready) seen = 1;
    end
    chk("rst_reach_wresp", 32'(seen), 32'd1);
    axi_reset_n = 0; wbs_cyc = 0; wbs_stb = 0;
    @(negedge clk);
    chk("midrst_ctrl", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, wbs_ack, busy}), 32'd0);
    chk("midrst_rdata", wbs_rdata, 32'h0);
    last_rdata = 32'h0;
    slv_clear();
    axi_reset_n = 1;
    do_txn(post_rst);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
